// File: rtl/psa_shift_pipe_pkg.sv
// -----------------------------------------------------------------------------
// psa_shift_pkg
// Shared types and constants for the psa_shift_pipe arithmetic/shift unit.
//   - op_e          : operation select encoding
//   - SAT_*         : lane saturation patterns (MSB bit and fill bit)
//   - s1_payload_t  : what stage 1 hands to stage 2
// The payload struct is sized by PSA_WIDTH / PSA_LANE. The top-level WIDTH and
// LANE parameters default to these values and must be kept equal to them.
// -----------------------------------------------------------------------------
package psa_shift_pkg;

  localparam int PSA_WIDTH  = 16;
  localparam int PSA_LANE   = 4;
  localparam int PSA_NLANES = PSA_WIDTH / PSA_LANE;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_PADD  = 3'b010,
    OP_PADDS = 3'b011,
    OP_SLL   = 3'b100,
    OP_SRA   = 3'b101,
    OP_ROR   = 3'b110,
    OP_ILL   = 3'b111
  } op_e;

  // Positive lane overflow clamps to 0111..1, negative to 1000..0.
  localparam logic SAT_POS_MSB  = 1'b0;
  localparam logic SAT_POS_FILL = 1'b1;
  localparam logic SAT_NEG_MSB  = 1'b1;
  localparam logic SAT_NEG_FILL = 1'b0;

  // lane_ovf doubles as the full-width overflow carrier for ADD/SUB: bit 0
  // holds the signed overflow and the other bits stay zero, so stage 2 can
  // form ovfl as a plain OR for every operation.
  typedef struct packed {
    logic [PSA_WIDTH-1:0]  raw;
    logic [PSA_NLANES-1:0] lane_ovf;
    logic [PSA_NLANES-1:0] lane_neg;
    op_e                   op;
  } s1_payload_t;

endpackage

// File: rtl/psa_shift_pipe_if.sv
// -----------------------------------------------------------------------------
// psa_shift_pipe_if
// Operand-issue and result-writeback bundle of psa_shift_pipe.
//   master : producer/consumer side (drives operands, out_ready)
//   slave  : the unit (drives in_ready, result and flags)
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. A valid source holds its payload stable until that edge; ready may
// depend combinationally on the consumer's ready but never on valid. While
// out_valid & ~out_ready, result and all flags are frozen.
// -----------------------------------------------------------------------------
interface psa_shift_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovfl;
  logic             zero;
  logic             neg;
  logic             err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, ovfl, zero, neg, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, ovfl, zero, neg, err
  );
endinterface

// File: rtl/psa_shift_pipe_lane_adder.sv
// -----------------------------------------------------------------------------
// lane_adder
// LANE-bit wrapping adder for one partition of the packed add.
//   i_a, i_b  : lane operands (two's complement)
//   o_sum     : i_a + i_b mod 2^LANE
//   o_ovf     : signed overflow of this lane
//   o_ovf_neg : 1 when the overflow went negative (only meaningful with o_ovf)
// -----------------------------------------------------------------------------
module lane_adder #(
  parameter int LANE = 4
) (
  input  logic [LANE-1:0] i_a,
  input  logic [LANE-1:0] i_b,
  output logic [LANE-1:0] o_sum,
  output logic            o_ovf,
  output logic            o_ovf_neg
);
  logic [LANE-1:0] w_sum;

  assign w_sum = i_a + i_b;
  assign o_sum = w_sum;
  // Overflow only when both operands share a sign and the sum flips it; the
  // direction of the overflow is then the operands' common sign.
  assign o_ovf     = (i_a[LANE-1] == i_b[LANE-1]) && (w_sum[LANE-1] != i_a[LANE-1]);
  assign o_ovf_neg = o_ovf & i_a[LANE-1];
endmodule

// File: rtl/psa_shift_pipe.sv
// -----------------------------------------------------------------------------
// psa_shift_pipe
// Two-stage pipelined add/sub, partitioned lane add (wrapping or saturating)
// and SLL/SRA/ROR shift unit, with a saturating count of delivered overflows.
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   bus      : psa_shift_pipe_if.slave (operand issue + result writeback)
//   clr_cnt  : synchronous clear of ovf_cnt (wins over an increment)
//   ovf_cnt  : saturating count of result handshakes with ovfl=1
// Stage 1 computes the raw result and overflow vectors; stage 2 applies lane
// saturation and registers the result with its flags.
// -----------------------------------------------------------------------------
module psa_shift_pipe
  import psa_shift_pkg::*;
#(
  parameter int WIDTH = PSA_WIDTH,
  parameter int LANE  = PSA_LANE,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  psa_shift_pipe_if.slave  bus
);
  localparam int NLANES = WIDTH / LANE;
  localparam int AW     = $clog2(WIDTH);
  localparam logic [LANE-1:0]  LANE_SAT_POS = {SAT_POS_MSB, {(LANE-1){SAT_POS_FILL}}};
  localparam logic [LANE-1:0]  LANE_SAT_NEG = {SAT_NEG_MSB, {(LANE-1){SAT_NEG_FILL}}};
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  // ---------------------------------------------------------------------------
  // Pipeline enables: the ready path is combinational back to the input so a
  // full pipe can shift in the same cycle the consumer takes a result.
  // ---------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_out_valid;
  logic w_s2_en;
  logic w_s1_en;
  logic w_out_fire;

  assign w_s2_en    = ~r_out_valid | bus.out_ready;
  assign w_s1_en    = ~r_s1_valid | w_s2_en;
  assign w_out_fire = r_out_valid & bus.out_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 datapath
  // ---------------------------------------------------------------------------
  op_e              w_op;
  logic [AW-1:0]    w_amt;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_lane_sum;
  logic [NLANES-1:0] w_lane_ovf;
  logic [NLANES-1:0] w_lane_neg;
  s1_payload_t      w_s1_next;

  assign w_op  = op_e'(bus.op);
  assign w_amt = bus.b[AW-1:0];

  assign w_add = bus.a + bus.b;
  assign w_sub = bus.a + ~bus.b + WIDTH'(1);
  assign w_add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_add[WIDTH-1] != bus.a[WIDTH-1]);
  assign w_sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_sub[WIDTH-1] != bus.a[WIDTH-1]);

  assign w_sll = bus.a << w_amt;
  assign w_sra = $signed(bus.a) >>> w_amt;

  // Rotate right: output bit i comes from input bit (i + amt) mod WIDTH; the
  // AW-bit index wraps naturally because WIDTH is a power of two.
  always_comb begin
    w_ror = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ror[i] = bus.a[w_amt + AW'(i)];
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    lane_adder #(
      .LANE (LANE)
    ) u_lane_adder (
      .i_a       (bus.a[g*LANE +: LANE]),
      .i_b       (bus.b[g*LANE +: LANE]),
      .o_sum     (w_lane_sum[g*LANE +: LANE]),
      .o_ovf     (w_lane_ovf[g]),
      .o_ovf_neg (w_lane_neg[g])
    );
  end

  always_comb begin
    w_s1_next    = '0;
    w_s1_next.op = w_op;
    case (w_op)
      OP_ADD: begin
        w_s1_next.raw         = w_add;
        w_s1_next.lane_ovf[0] = w_add_ovf;
      end
      OP_SUB: begin
        w_s1_next.raw         = w_sub;
        w_s1_next.lane_ovf[0] = w_sub_ovf;
      end
      OP_PADD, OP_PADDS: begin
        w_s1_next.raw      = w_lane_sum;
        w_s1_next.lane_ovf = w_lane_ovf;
        w_s1_next.lane_neg = w_lane_neg;
      end
      OP_SLL:  w_s1_next.raw = w_sll;
      OP_SRA:  w_s1_next.raw = w_sra;
      OP_ROR:  w_s1_next.raw = w_ror;
      default: w_s1_next.raw = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 1 register
  // ---------------------------------------------------------------------------
  s1_payload_t r_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1 <= w_s1_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturation and flags
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_s2_result;
  logic             w_s2_ovfl;
  logic             w_s2_err;

  always_comb begin
    w_s2_result = r_s1.raw;
    if (r_s1.op == OP_PADDS) begin
      for (int l = 0; l < NLANES; l++) begin
        if (r_s1.lane_ovf[l]) begin
          w_s2_result[l*LANE +: LANE] = r_s1.lane_neg[l] ? LANE_SAT_NEG : LANE_SAT_POS;
        end
      end
    end
  end

  assign w_s2_ovfl = |r_s1.lane_ovf;
  assign w_s2_err  = (r_s1.op == OP_ILL);

  logic [WIDTH-1:0] r_result;
  logic             r_ovfl;
  logic             r_zero;
  logic             r_neg;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovfl      <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_s2_result;
        r_ovfl   <= w_s2_ovfl;
        r_zero   <= (w_s2_result == '0);
        r_neg    <= w_s2_result[WIDTH-1];
        r_err    <= w_s2_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow event counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (clr_cnt) begin
      r_ovf_cnt <= '0;
    end else if (w_out_fire && r_ovfl && (r_ovf_cnt != CNT_MAX)) begin
      r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = w_s1_en;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.ovfl      = r_ovfl;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.err       = r_err;
  assign ovf_cnt       = r_ovf_cnt;

endmodule

// File: tb/tb_psa_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_psa_shift_pipe
// Bench for psa_shift_pipe with WIDTH=16, LANE=4, CNT_W=8. Inputs change 1
// time unit after a rising edge; outputs are observed on the falling edge.
// Expected results come from model(), which evaluates each operation with
// integer arithmetic; a falling-edge monitor pops exp_q on every result
// handshake and tracks the expected overflow count.
// -----------------------------------------------------------------------------
module tb_psa_shift_pipe;
  localparam int WIDTH = 16;
  localparam int LANE  = 4;
  localparam int CNT_W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  logic clr_cnt;
  logic [CNT_W-1:0] ovf_cnt;

  always #5 clk = ~clk;

  psa_shift_pipe_if #(.WIDTH(WIDTH)) bus ();

  psa_shift_pipe #(
    .WIDTH (WIDTH),
    .LANE  (LANE),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr_cnt (clr_cnt),
    .ovf_cnt (ovf_cnt),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Packed observation: {err, neg, zero, ovfl, result}
  logic [19:0] obs;
  assign obs = {bus.err, bus.neg, bus.zero, bus.ovfl, bus.result};

  logic [19:0] exp_q[$];
  int          mdl_cnt = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    int r;
    int s;
    int amt;
    int la;
    int lb;
    int ls;
    int lv;
    bit ov;
    bit er;
    logic [3:0] lane_a;
    logic [3:0] lane_b;
    r   = 0;
    ov  = 1'b0;
    er  = 1'b0;
    amt = int'(b[3:0]);
    case (op)
      3'd0: begin
        s  = int'($signed(a)) + int'($signed(b));
        ov = (s > 32767) || (s < -32768);
        r  = s & 32'hFFFF;
      end
      3'd1: begin
        s  = int'($signed(a)) - int'($signed(b));
        ov = (s > 32767) || (s < -32768);
        r  = s & 32'hFFFF;
      end
      3'd2, 3'd3: begin
        for (int l = 0; l < 4; l++) begin
          lane_a = a[l*4 +: 4];
          lane_b = b[l*4 +: 4];
          la = int'($signed(lane_a));
          lb = int'($signed(lane_b));
          ls = la + lb;
          lv = ls;
          if (ls > 7 || ls < -8) begin
            ov = 1'b1;
            if (op == 3'd3) lv = (ls > 7) ? 7 : -8;
          end
          r = r | ((lv & 15) << (4 * l));
        end
      end
      3'd4: r = (int'(a) << amt) & 32'hFFFF;
      3'd5: r = (int'($signed(a)) >>> amt) & 32'hFFFF;
      3'd6: r = ((int'(a) >> amt) | (int'(a) << (16 - amt))) & 32'hFFFF;
      default: begin
        r  = 0;
        er = 1'b1;
      end
    endcase
    return {er, r[15], (r == 0), ov, r[15:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor (falling edge)
  // ---------------------------------------------------------------------------
  bit          stall_seen = 1'b0;
  logic [19:0] stall_val;
  logic [19:0] exp_item;

  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
      mdl_cnt    = 0;
    end else begin
      if (stall_seen && bus.out_valid) begin
        checks++;
        if (obs !== stall_val) begin
          failures++;
          $display("FAIL stall_hold got=%h exp=%h t=%0t", obs, stall_val, $time);
        end
      end
      stall_seen = bus.out_valid && !bus.out_ready;
      stall_val  = obs;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got=%h exp=none t=%0t", obs, $time);
        end else begin
          exp_item = exp_q.pop_front();
          if (obs !== exp_item) begin
            failures++;
            $display("FAIL scoreboard got=%h exp=%h t=%0t", obs, exp_item, $time);
          end
          if (exp_item[16] && mdl_cnt < 255) mdl_cnt++;
        end
      end
      if (clr_cnt) mdl_cnt = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    int cyc = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    @(negedge clk);
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL send_timeout in_ready=%b exp=1", bus.in_ready);
    end else begin
      exp_q.push_back(model(a, b, op));
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (!bus.out_valid && exp_q.size() == 0) break;
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (obs !== 20'h0) begin
      failures++; $display("FAIL reset_flags got=%h exp=00000", obs);
    end
    checks++;
    if (ovf_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", ovf_cnt);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [12];
    logic [15:0] tb_ [12];
    logic [2:0]  top [12];
    logic [19:0] texp [12];
    bit          seen;
    ta   = '{16'h7777, 16'h7777, 16'h8888, 16'h8000, 16'h0001, 16'h0001,
             16'h1234, 16'h8000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h7000};
    tb_  = '{16'h1111, 16'h1111, 16'h8888, 16'h000F, 16'h000F, 16'h0001,
             16'h0010, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0004};
    top  = '{3'd2, 3'd3, 3'd3, 3'd5, 3'd4, 3'd6, 3'd6, 3'd1, 3'd0, 3'd7, 3'd0, 3'd5};
    texp = '{20'h58888, 20'h17777, 20'h58888, 20'h4FFFF, 20'h48000, 20'h48000,
             20'h01234, 20'h17FFF, 20'h20000, 20'hA0000, 20'h58000, 20'h00700};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(ta[i], tb_[i], top[i]);
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        @(negedge clk);
        if (bus.out_valid) seen = 1'b1;
      end
      checks++;
      if (!seen || obs !== texp[i]) begin
        failures++;
        $display("FAIL directed[%0d] got=%h exp=%h valid=%b", i, obs, texp[i], seen);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic [2:0]  ov [3];
    logic [19:0] held;
    bit          have = 1'b0;
    int          acc  = 0;
    for (int i = 0; i < 3; i++) begin
      av[i] = 16'($urandom_range(0, 65535));
      bv[i] = 16'($urandom_range(0, 65535));
      ov[i] = 3'($urandom_range(0, 6));
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = av[0]; bus.b = bv[0]; bus.op = ov[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (!have) begin
          held = obs;
          have = 1'b1;
        end else begin
          checks++;
          if (obs !== held) begin
            failures++; $display("FAIL bp_hold got=%h exp=%h", obs, held);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(av[acc], bv[acc], ov[acc]));
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 3) begin
        bus.a = av[acc]; bus.b = bv[acc]; bus.op = ov[acc];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    checks++;
    if (acc != 2) begin
      failures++; $display("FAIL bp_accepts got=%0d exp=2", acc);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready);
    end
    // Release: third op must be accepted while the first result leaves.
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release in_ready=%b out_valid=%b exp=1,1", bus.in_ready, bus.out_valid);
    end
    if (bus.in_valid && bus.in_ready && acc < 3) begin
      exp_q.push_back(model(av[acc], bv[acc], ov[acc]));
      acc++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_stream[%0d] got=%b exp=1", c, bus.out_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_empty out_valid=%b pending=%0d exp=0,0", bus.out_valid, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_counter();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) send(16'h7FFF, 16'h0001, 3'd0);
    drain();
    checks++;
    if (ovf_cnt !== 8'd255) begin
      failures++; $display("FAIL cnt_saturate got=%0d exp=255", ovf_cnt);
    end
    // Plain clear
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    checks++;
    if (ovf_cnt !== 8'd0) begin
      failures++; $display("FAIL cnt_clear got=%0d exp=0", ovf_cnt);
    end
    // One overflowing handshake
    send(16'h8000, 16'h0001, 3'd1);
    drain();
    checks++;
    if (ovf_cnt !== 8'd1) begin
      failures++; $display("FAIL cnt_one got=%0d exp=1", ovf_cnt);
    end
    // Clear in the same cycle as an overflowing handshake
    send(16'h7777, 16'h1111, 3'd2);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL cnt_clr_setup got=%b exp=1", bus.out_valid);
    end
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    checks++;
    if (ovf_cnt !== 8'd0) begin
      failures++; $display("FAIL cnt_clr_priority got=%0d exp=0", ovf_cnt);
    end
    // Stalled result must not count
    bus.out_ready = 1'b0;
    send(16'h7FFF, 16'h7FFF, 3'd0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checks++;
    if (ovf_cnt !== 8'd0 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL cnt_stall got=%0d valid=%b exp=0,1", ovf_cnt, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ovf_cnt !== 8'd1) begin
      failures++; $display("FAIL cnt_release got=%0d exp=1", ovf_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(16'h7FFF, 16'h0001, 3'd0);
    send(16'h8000, 16'h0001, 3'd1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_full out_valid=%b in_ready=%b exp=1,0", bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || obs !== 20'h0 || ovf_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_state out_valid=%b flags=%h cnt=%0d exp=0,00000,0",
               bus.out_valid, obs, ovf_cnt);
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready);
    end
    send(16'h1234, 16'h0001, 3'd0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_early got=%b exp=0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || obs !== 20'h01235) begin
      failures++;
      $display("FAIL rstmid_first valid=%b got=%h exp=1,01235", bus.out_valid, obs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit          done = 1'b0;
    logic [15:0] edge_v [4];
    edge_v = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    fork
      begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  rop;
        for (int i = 0; i < 200; i++) begin
          ra  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)]
                                            : 16'($urandom_range(0, 65535));
          rb  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)]
                                            : 16'($urandom_range(0, 65535));
          rop = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
          send(ra, rb, rop);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
    checks++;
    if (int'(ovf_cnt) != mdl_cnt) begin
      failures++; $display("FAIL random_cnt got=%0d exp=%0d", ovf_cnt, mdl_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst           = 1'b1;
    clr_cnt       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    test_reset();
    test_directed();
    test_backpressure();
    test_counter();
    test_reset_mid();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
